// File: rtl/tff_counter_sequencer_if.sv
// Command channel between a command source and tff_counter_sequencer.
// Carries the valid/ready handshake plus the terminal count and the auto-reload request.
interface tff_counter_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_limit;
    logic             cmd_reload;

    // Command source side
    modport master (
        output cmd_valid,
        output cmd_limit,
        output cmd_reload,
        input  cmd_ready
    );

    // Sequencer side
    modport slave (
        input  cmd_valid,
        input  cmd_limit,
        input  cmd_reload,
        output cmd_ready
    );
endinterface

// File: rtl/tff_counter_sequencer.sv
// Sequencer for an up-counter.
// - Accepts a terminal count.
// - Clears the counter, enables it until q reaches that count, then pulses done.
// Optional feature: define COUNTER_SEQ_AUTORELOAD_EN to let a command with cmd_reload=1
// loop back to the clear step on every completion. The loop ends only on abort or clear.
module tff_counter_sequencer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  clear,
    tff_counter_sequencer_if.slave cmd,
    input  logic                  pause,
    input  logic                  abort,
    output logic                  cnt_clear_n,
    output logic                  cnt_enable,
    input  logic [CNT_W-1:0]      cnt_q,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] lim;
    logic             rld;
    logic             accept;
    logic             at_lim;
    logic             ready;

    assign accept = (state == S_IDLE) && cmd.cmd_valid;
    assign at_lim = (cnt_q == lim);
    assign cmd.cmd_ready = ready;

    // State register
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Terminal count capture on accept
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            lim <= CNT_W'(0);
        end else if (accept) begin
            lim <= cmd.cmd_limit;
        end
    end

`ifdef COUNTER_SEQ_AUTORELOAD_EN
    // Auto-reload flag capture on accept
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            rld <= 1'b0;
        end else if (accept) begin
            rld <= cmd.cmd_reload;
        end
    end
`else
    assign rld = 1'b0;
`endif

    // Completion pulse: one cycle after the run reaches its limit without an abort
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            done <= 1'b0;
        end else begin
            done <= (state == S_RUN) && at_lim && !abort;
        end
    end

    // Next-state and combinational outputs
    always_comb begin
        state_nxt   = state;
        ready       = 1'b0;
        busy        = 1'b1;
        cnt_enable  = 1'b0;
        cnt_clear_n = ~clear;

        case (state)
            S_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (cmd.cmd_valid) begin
                    state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                cnt_clear_n = 1'b0;
                state_nxt   = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                // Enable drops at the limit, so pause never competes with completion
                cnt_enable = !pause && !at_lim;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (at_lim && rld) begin
                    state_nxt = S_CLR;
                end else if (at_lim) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tff_counter_sequencer.sv
// Directed bench for tff_counter_sequencer driving a behavioural up-counter.
// Cycle numbering is counted from the command cycle (cycle 0). Samples are taken 1 time unit after each rising edge.
module tb_tff_counter_sequencer;

    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             clear;
    logic             pause;
    logic             abort;
    logic             cnt_clear_n;
    logic             cnt_enable;
    logic [CNT_W-1:0] cnt_q;
    logic             busy;
    logic             done;

    int n_asserts;
    int n_fail;
    int en_count;

    tff_counter_sequencer_if #(.CNT_W(CNT_W)) cmd_bus ();

    tff_counter_sequencer #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .clear       (clear),
        .cmd         (cmd_bus.slave),
        .pause       (pause),
        .abort       (abort),
        .cnt_clear_n (cnt_clear_n),
        .cnt_enable  (cnt_enable),
        .cnt_q       (cnt_q),
        .busy        (busy),
        .done        (done)
    );

    // Counter under control: synchronous active-low clear, +1 when enabled
    always_ff @(posedge clk) begin
        if (!cnt_clear_n) begin
            cnt_q <= '0;
        end else if (cnt_enable) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a command in the current cycle (cycle 0); returns in cycle 1
    task automatic issue(input logic [7:0] limit, input logic reload);
        cmd_bus.cmd_valid  = 1'b1;
        cmd_bus.cmd_limit  = limit;
        cmd_bus.cmd_reload = reload;
        check("ready_at_accept", 32'(cmd_bus.cmd_ready), 32'd1);
        tick();
        cmd_bus.cmd_valid  = 1'b0;
        cmd_bus.cmd_reload = 1'b0;
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        clear     = 1'b1;
        pause     = 1'b0;
        abort     = 1'b0;
        cmd_bus.cmd_valid  = 1'b0;
        cmd_bus.cmd_limit  = 8'd0;
        cmd_bus.cmd_reload = 1'b0;

        // ---------------- reset values ----------------
        tick();
        tick();
        check("rst_clear_n", 32'(cnt_clear_n), 32'd0);
        check("rst_ready",   32'(cmd_bus.cmd_ready), 32'd1);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_done",    32'(done), 32'd0);
        check("rst_enable",  32'(cnt_enable), 32'd0);
        check("rst_q",       32'(cnt_q), 32'd0);
        clear = 1'b0;
        #1;
        check("rel_clear_n", 32'(cnt_clear_n), 32'd1);
        tick();

        // ---------------- basic run, limit 5 ----------------
        issue(8'd5, 1'b0);
        check("b_c1_clear_n", 32'(cnt_clear_n), 32'd0);
        check("b_c1_busy",    32'(busy), 32'd1);
        check("b_c1_ready",   32'(cmd_bus.cmd_ready), 32'd0);
        check("b_c1_enable",  32'(cnt_enable), 32'd0);
        for (int c = 2; c <= 6; c++) begin
            tick();
            check("b_run_enable", 32'(cnt_enable), 32'd1);
            check("b_run_q",      32'(cnt_q), 32'(c - 2));
            check("b_run_done",   32'(done), 32'd0);
        end
        tick(); // cycle 7
        check("b_c7_q",      32'(cnt_q), 32'd5);
        check("b_c7_enable", 32'(cnt_enable), 32'd0);
        check("b_c7_done",   32'(done), 32'd0);
        tick(); // cycle 8
        check("b_c8_done",   32'(done), 32'd1);
        check("b_c8_busy",   32'(busy), 32'd1);
        tick(); // cycle 9
        check("b_c9_done",   32'(done), 32'd0);
        check("b_c9_ready",  32'(cmd_bus.cmd_ready), 32'd1);
        check("b_c9_busy",   32'(busy), 32'd0);
        check("b_c9_q",      32'(cnt_q), 32'd5);

        // ---------------- reset mid-count ----------------
        issue(8'd10, 1'b0);
        tick(); tick(); tick(); // cycle 4, q = 2
        check("mr_q_before", 32'(cnt_q), 32'd2);
        clear = 1'b1;
        #1;
        check("mr_clear_n",  32'(cnt_clear_n), 32'd0);
        check("mr_busy",     32'(busy), 32'd0);
        check("mr_enable",   32'(cnt_enable), 32'd0);
        tick();
        clear = 1'b0;
        #1;
        check("mr_ready",    32'(cmd_bus.cmd_ready), 32'd1);
        check("mr_q",        32'(cnt_q), 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("mr_no_done", 32'(done), 32'd0);
            check("mr_q_hold",  32'(cnt_q), 32'd0);
        end

        // ---------------- limit 0 ----------------
        issue(8'd0, 1'b0);
        check("z_c1_enable", 32'(cnt_enable), 32'd0);
        tick(); // cycle 2
        check("z_c2_enable", 32'(cnt_enable), 32'd0);
        check("z_c2_busy",   32'(busy), 32'd1);
        check("z_c2_done",   32'(done), 32'd0);
        tick(); // cycle 3
        check("z_c3_done",   32'(done), 32'd1);
        check("z_c3_q",      32'(cnt_q), 32'd0);
        tick(); // cycle 4
        check("z_c4_done",   32'(done), 32'd0);
        check("z_c4_ready",  32'(cmd_bus.cmd_ready), 32'd1);

        // ---------------- limit 255, no wrap ----------------
        issue(8'd255, 1'b0);
        en_count = 0;
        for (int c = 2; c <= 256; c++) begin
            tick();
            if (cnt_enable) en_count++;
        end
        check("f_enable_cycles", 32'(en_count), 32'd255);
        tick(); // cycle 257
        check("f_c257_q",      32'(cnt_q), 32'd255);
        check("f_c257_enable", 32'(cnt_enable), 32'd0);
        check("f_c257_done",   32'(done), 32'd0);
        tick(); // cycle 258
        check("f_c258_done",   32'(done), 32'd1);
        tick(); // cycle 259
        check("f_c259_q",      32'(cnt_q), 32'd255);
        check("f_c259_ready",  32'(cmd_bus.cmd_ready), 32'd1);

        // ---------------- pause, limit 4 ----------------
        issue(8'd4, 1'b0);
        tick(); tick(); tick(); // cycle 4, q = 2
        check("p_c4_q", 32'(cnt_q), 32'd2);
        pause = 1'b1;
        for (int c = 4; c <= 6; c++) begin
            #1;
            check("p_hold_enable", 32'(cnt_enable), 32'd0);
            check("p_hold_q",      32'(cnt_q), 32'd2);
            tick();
        end
        pause = 1'b0; // cycle 7
        check("p_c7_q", 32'(cnt_q), 32'd2);
        for (int c = 7; c <= 9; c++) begin
            check("p_no_early_done", 32'(done), 32'd0);
            tick();
        end
        check("p_c10_done", 32'(done), 32'd1);
        check("p_c10_q",    32'(cnt_q), 32'd4);
        tick();
        check("p_c11_done", 32'(done), 32'd0);

        // ---------------- abort, limit 10 ----------------
        issue(8'd10, 1'b0);
        tick(); tick(); tick(); // cycle 4, q = 2, this edge lifts q to 3
        check("a_c4_q", 32'(cnt_q), 32'd2);
        abort = 1'b1;
        tick(); // cycle 5
        abort = 1'b0;
        check("a_idle_busy",  32'(busy), 32'd0);
        check("a_idle_ready", 32'(cmd_bus.cmd_ready), 32'd1);
        check("a_no_done",    32'(done), 32'd0);
        check("a_q",          32'(cnt_q), 32'd3);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("a_q_hold",    32'(cnt_q), 32'd3);
            check("a_done_hold", 32'(done), 32'd0);
        end

        // ---------------- cmd_valid while busy, limit 2 ----------------
        issue(8'd2, 1'b0);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_limit = 8'd6;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check("bz_ready", 32'(cmd_bus.cmd_ready), 32'd0);
            if (c < 4) tick();
        end
        check("bz_c4_q",      32'(cnt_q), 32'd2);
        check("bz_c4_enable", 32'(cnt_enable), 32'd0);
        cmd_bus.cmd_valid = 1'b0;
        tick(); // cycle 5
        check("bz_c5_done",  32'(done), 32'd1);
        tick(); // cycle 6
        check("bz_c6_ready", 32'(cmd_bus.cmd_ready), 32'd1);
        check("bz_c6_q",     32'(cnt_q), 32'd2);

        // ---------------- reload request, limit 3 ----------------
        issue(8'd3, 1'b1);
        for (int c = 2; c <= 17; c++) begin
            tick();
`ifdef COUNTER_SEQ_AUTORELOAD_EN
            check("r_done", 32'(done), 32'((c == 6) || (c == 11) || (c == 16)));
            check("r_busy", 32'(busy), 32'd1);
            if (c == 10) check("r_q_peak", 32'(cnt_q), 32'd3);
            if (c == 17) abort = 1'b1;
`else
            check("r_done", 32'(done), 32'(c == 6));
            if (c >= 7) check("r_idle", 32'(busy), 32'd0);
`endif
        end
        tick(); // cycle 18
        abort = 1'b0;
        check("r_end_ready", 32'(cmd_bus.cmd_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("r_end_no_done", 32'(done), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/tff_counter_sequencer.md
# tff_counter_sequencer

Controller for the 8-bit T-flip-flop counter. It accepts a run command carrying a terminal count. It then sequences the counter's `clear_n` and `enable` inputs so the counter clears and counts up to exactly that value, and reports completion with a one-cycle `done` pulse. It sits between a command source (testbench or higher-level control) and one counter instance, and observes the counter's `q` output.

## Interface
- `CNT_W`, default 8: width of the counter and the terminal count.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_limit`  in  CNT_W  terminal count, captured on accept.
- `cmd_reload`  in  1  auto-reload request, captured on accept.
  - Present in both builds.
  - Ignored unless `COUNTER_SEQ_AUTORELOAD_EN` is defined.
- `pause`  in  1  freezes counting while high; level-sensitive.
- `abort`  in  1  cancels the active run.
- `cnt_clear_n`  out  1  drives the counter's `clear_n` (active-low).
- `cnt_enable`  out  1  drives the counter's `enable`.
- `cnt_q`  in  CNT_W  counter's `q`.
- `busy`  out  1  run in progress (state != IDLE).
- `done`  out  1  one-cycle pulse on run completion.

## Operation
- **States:** IDLE, CLR, RUN, DONE. State is registered.
- **Registered `lim` and `rld`:** both loaded on accept.
- **Accept:** IDLE && `cmd_valid`. `cmd_ready` = (state == IDLE).
- **Transitions** (`abort` has the highest priority in CLR, RUN and DONE):
  - IDLE: accept -> CLR; otherwise stay.
  - CLR: abort -> IDLE; otherwise -> RUN.
  - RUN, abort -> IDLE, no `done` pulse.
  - RUN, `cnt_q` == `lim` and `rld` == 1 (macro builds only) -> CLR.
  - RUN, `cnt_q` == `lim` otherwise -> DONE.
  - RUN, neither condition -> stay.
  - DONE: -> IDLE unconditionally. `abort` in DONE also -> IDLE, and `done` still pulses.
- **`cnt_clear_n`:** `~(clear | state == CLR)`, combinational. The counter is therefore also cleared while the sequencer is in reset.
- **`cnt_enable`:** (state == RUN) && !`pause` && (`cnt_q` != `lim`), combinational. The counter never increments past `lim`.
- **`done`:** registered. Set for the cycle after a RUN cycle where `cnt_q` == `lim` and `abort` == 0; otherwise 0.
- **`abort`:** leaves the counter holding its current value. The next command clears it.
- **`cmd_limit` == 0:** zero enable cycles; completes through CLR -> RUN -> DONE.
- **`pause`:** in IDLE, CLR and DONE it has no effect. `pause` and completion in the same RUN cycle: completion wins, because enable is already 0 at `q` == `lim`.
- **Counter width:** the counter is a free-running +1 up-counter. `lim` is unsigned CNT_W bits and is never exceeded, so the counter never wraps.

## Timing
- **Reset values:** state = IDLE, `lim` = 0, `rld` = 0, `done` = 0, `busy` = 0, `cmd_ready` = 1, `cnt_enable` = 0.
- **`cnt_clear_n` in reset:** 0 while `clear` is high, 1 after release.
- **Latency:**
  - Command accepted at the edge ending cycle 0.
  - Cycle 1: CLR, `cnt_clear_n` = 0.
  - Cycles 2..L+1: RUN with `cnt_enable` = 1, plus P paused cycles.
  - Cycle L+2+P: RUN with `q` = L.
  - Cycle L+3+P: DONE with `done` = 1.
  - Cycle L+4+P: IDLE, `cmd_ready` = 1.
- **Reset mid-run:** immediate return to IDLE and counter cleared. No `done` pulse is generated.
- **`cmd_valid` while busy:** ignored, since `cmd_ready` = 0. The source must hold the command until accepted.

## Configuration
- **`COUNTER_SEQ_AUTORELOAD_EN` defined:**
  - A run captured with `cmd_reload` = 1 loops RUN -> CLR on each completion.
  - `done` pulses in each CLR cycle; period = L+2 cycles with no pause.
  - `busy` stays 1 and the run ends only by `abort` or `clear`.
- **Not defined:**
  - `rld` is tied to 0 and `cmd_reload` is unused.
  - Every run ends in DONE -> IDLE.

## Test plan
- **Reset:** `clear` pulse mid-count -> `cnt_clear_n` = 0 during `clear`; after release `cmd_ready` = 1, `busy` = 0, `done` = 0, `cnt_q` = 0.
- **Basic run:** `cmd_limit` = 5, `cmd_valid` for one cycle at cycle 0 -> `cnt_clear_n` low in cycle 1, `cnt_enable` high in cycles 2-6, `cnt_q` = 5 in cycle 7, `done` = 1 in cycle 8 only, `cmd_ready` = 1 in cycle 9.
- **Limits:**
  - `cmd_limit` = 0 -> `cnt_enable` never high; `done` in cycle 3.
  - `cmd_limit` = 255 -> `cnt_q` = 255, no wrap; `done` in cycle 258.
- **Pause:** `cmd_limit` = 4, `pause` high for 3 cycles while `cnt_q` = 2 -> `cnt_q` holds at 2; `done` is delayed by exactly 3 cycles to cycle 10.
- **Abort and busy:**
  - `abort` at `cnt_q` = 3 with `cmd_limit` = 10 -> IDLE next cycle, no `done`, `cnt_q` holds at 3.
  - `cmd_valid` while busy -> not accepted, `lim` unchanged.
- **Reload** (macro defined): `cmd_limit` = 3, `cmd_reload` = 1 -> `done` pulses every 5 cycles (cycles 6, 11, 16 ...) and `cnt_q` cycles 0..3. `abort` -> IDLE, pulses stop. Without the macro, the same stimulus -> a single `done`, then IDLE.
